// File: rtl/tx_frame_mux.sv
// PHY transmit framing sequencer: wraps upstream packets in STP/END and inserts
// periodic COM+SKP ordered sets between packets, one registered symbol per clock.
module tx_frame_mux #(
    parameter int         DATA_W       = 8,
    parameter int         SKP_INTERVAL = 16,
    parameter int         OS_LEN       = 4,
    parameter logic [7:0] STP_SYM      = 8'hFB,
    parameter logic [7:0] END_SYM      = 8'hFD,
    parameter logic [7:0] COM_SYM      = 8'hBC,
    parameter logic [7:0] SKP_SYM      = 8'h1C,
    parameter logic [7:0] IDLE_SYM     = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] pkt_data,
    input  logic              pkt_last,
    output logic              pkt_ready,
    output logic [DATA_W-1:0] D_out,
    output logic              valid,
    output logic [1:0]        sel,
    output logic              os_active
);

    localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam int OS_W  = $clog2(OS_LEN);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS_LEN - 1);

    localparam logic [DATA_W-1:0] W_STP  = DATA_W'(STP_SYM);
    localparam logic [DATA_W-1:0] W_END  = DATA_W'(END_SYM);
    localparam logic [DATA_W-1:0] W_COM  = DATA_W'(COM_SYM);
    localparam logic [DATA_W-1:0] W_SKP  = DATA_W'(SKP_SYM);
    localparam logic [DATA_W-1:0] W_IDLE = DATA_W'(IDLE_SYM);

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_FRM  = 2'b01;
    localparam logic [1:0] SEL_SKP  = 2'b10;
    localparam logic [1:0] SEL_COM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_END,
        ST_OS
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [OS_W-1:0]   r_os_cnt;
    logic [DATA_W-1:0] r_d_out;
    logic              r_valid;
    logic [1:0]        r_sel;
    logic              r_os_active;
    logic              w_due;

    assign w_due     = (r_cnt == CNT_MAX);
    assign pkt_ready = (r_state == ST_DATA) && !reset;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; the async reset branch restores the idle framing at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_os_cnt    <= '0;
            r_d_out     <= W_IDLE;
            r_valid     <= 1'b0;
            r_sel       <= SEL_COM;
            r_os_active <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_os_active <= 1'b0;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            unique case (r_state)
                ST_IDLE: begin
                    // A due ordered set has priority over a waiting packet.
                    if (w_due) begin
                        r_d_out     <= W_COM;
                        r_sel       <= SEL_COM;
                        r_os_active <= 1'b1;
                        r_os_cnt    <= OS_W'(1);
                        r_cnt       <= '0;
                        r_state     <= ST_OS;
                    end else if (pkt_valid) begin
                        r_d_out <= W_STP;
                        r_sel   <= SEL_FRM;
                        r_state <= ST_DATA;
                    end else begin
                        r_d_out <= W_IDLE;
                        r_sel   <= SEL_COM;
                    end
                end
                ST_DATA: begin
                    if (pkt_valid) begin
                        r_d_out <= pkt_data;
                        r_valid <= 1'b1;
                        r_sel   <= SEL_DATA;
                        if (pkt_last) begin
                            r_state <= ST_END;
                        end
                    end else begin
                        r_d_out <= W_IDLE;
                        r_sel   <= SEL_COM;
                    end
                end
                ST_END: begin
                    r_d_out <= W_END;
                    r_sel   <= SEL_FRM;
                    r_state <= ST_IDLE;
                end
                ST_OS: begin
                    r_d_out     <= W_SKP;
                    r_sel       <= SEL_SKP;
                    r_os_active <= 1'b1;
                    r_os_cnt    <= r_os_cnt + OS_W'(1);
                    if (r_os_cnt == OS_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign D_out     = r_d_out;
    assign valid     = r_valid;
    assign sel       = r_sel;
    assign os_active = r_os_active;

endmodule

// File: tb/tb_tx_frame_mux.sv
// Directed bench for tx_frame_mux: default instance plus a DATA_W=10, OS_LEN=3,
// SKP_INTERVAL=8 instance; edges are numbered from the first rising edge after reset release.
module tb_tx_frame_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [7:0] pkt_data = '0;
    logic       pkt_last = 1'b0;
    logic       pkt_ready;
    logic [7:0] d_out;
    logic       valid;
    logic [1:0] sel;
    logic       os_active;

    logic       reset2 = 1'b1;
    logic       pkt_valid2 = 1'b0;
    logic [9:0] pkt_data2 = '0;
    logic       pkt_last2 = 1'b0;
    logic       pkt_ready2;
    logic [9:0] d_out2;
    logic       valid2;
    logic [1:0] sel2;
    logic       os_active2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tx_frame_mux dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_last(pkt_last), .pkt_ready(pkt_ready), .D_out(d_out), .valid(valid),
        .sel(sel), .os_active(os_active)
    );

    tx_frame_mux #(.DATA_W(10), .SKP_INTERVAL(8), .OS_LEN(3)) dut2 (
        .clk(clk), .reset(reset2), .pkt_valid(pkt_valid2), .pkt_data(pkt_data2),
        .pkt_last(pkt_last2), .pkt_ready(pkt_ready2), .D_out(d_out2), .valid(valid2),
        .sel(sel2), .os_active(os_active2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic v,
                              input logic [1:0] s, input logic o);
        check({tag, ".d_out"}, 32'(d_out), d);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".os_active"}, 32'(os_active), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one edge, checks the reset state, releases mid-cycle.
    task automatic start_reset(input string tag);
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_data  = '0;
        tick();
        expect_out({tag, "_rst"}, 32'h00, 1'b0, 2'b11, 1'b0);
        check({tag, "_rst.ready"}, 32'(pkt_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Idle traffic: COM on multiples of 16, SKP on the three edges after it.
    task automatic run_idle(input string tag, input int first, input int last);
        for (int e = first; e <= last; e++) begin
            tick();
            if (e % 16 == 0)
                expect_out($sformatf("%s_e%0d", tag, e), 32'hBC, 1'b0, 2'b11, 1'b1);
            else if (e > 16 && e % 16 <= 3)
                expect_out($sformatf("%s_e%0d", tag, e), 32'h1C, 1'b0, 2'b10, 1'b1);
            else
                expect_out($sformatf("%s_e%0d", tag, e), 32'h00, 1'b0, 2'b11, 1'b0);
        end
    endtask

    initial begin
        // Scenario 1: no traffic.
        start_reset("s1");
        run_idle("s1", 1, 32);

        // Scenario 2: three-symbol packet, valid raised after edge 2.
        start_reset("s2");
        run_idle("s2", 1, 2);
        check("s2_ready_idle", 32'(pkt_ready), 32'd0);
        pkt_valid = 1'b1; pkt_data = 8'hA1; pkt_last = 1'b0;
        tick();
        expect_out("s2_e3", 32'hFB, 1'b0, 2'b01, 1'b0);
        check("s2_ready_e3", 32'(pkt_ready), 32'd1);
        tick();
        expect_out("s2_e4", 32'hA1, 1'b1, 2'b00, 1'b0);
        pkt_data = 8'hA2;
        tick();
        expect_out("s2_e5", 32'hA2, 1'b1, 2'b00, 1'b0);
        pkt_data = 8'hA3; pkt_last = 1'b1;
        tick();
        expect_out("s2_e6", 32'hA3, 1'b1, 2'b00, 1'b0);
        check("s2_ready_end", 32'(pkt_ready), 32'd0);
        pkt_valid = 1'b0; pkt_last = 1'b0;
        tick();
        expect_out("s2_e7", 32'hFD, 1'b0, 2'b01, 1'b0);
        tick();
        expect_out("s2_e8", 32'h00, 1'b0, 2'b11, 1'b0);

        // Scenario 3: 20-symbol packet spanning the due point.
        start_reset("s3");
        pkt_valid = 1'b1;
        tick();
        expect_out("s3_e1", 32'hFB, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pkt_data = 8'(8'h40 + i);
            pkt_last = (i == 19);
            tick();
            expect_out($sformatf("s3_e%0d", i + 2), 32'(8'h40 + i), 1'b1, 2'b00, 1'b0);
        end
        pkt_valid = 1'b0; pkt_last = 1'b0;
        tick();
        expect_out("s3_e22", 32'hFD, 1'b0, 2'b01, 1'b0);
        tick();
        expect_out("s3_e23", 32'hBC, 1'b0, 2'b11, 1'b1);
        for (int e = 24; e <= 26; e++) begin
            tick();
            expect_out($sformatf("s3_e%0d", e), 32'h1C, 1'b0, 2'b10, 1'b1);
        end
        for (int e = 27; e <= 38; e++) begin
            tick();
            expect_out($sformatf("s3_e%0d", e), 32'h00, 1'b0, 2'b11, 1'b0);
        end
        tick();
        expect_out("s3_e39", 32'hBC, 1'b0, 2'b11, 1'b1);

        // Scenario 4: two-cycle underrun mid-packet.
        start_reset("s4");
        pkt_valid = 1'b1;
        tick();
        expect_out("s4_e1", 32'hFB, 1'b0, 2'b01, 1'b0);
        pkt_data = 8'h31;
        tick();
        expect_out("s4_e2", 32'h31, 1'b1, 2'b00, 1'b0);
        pkt_valid = 1'b0; pkt_data = 8'hEE; pkt_last = 1'b1;
        tick();
        expect_out("s4_e3", 32'h00, 1'b0, 2'b11, 1'b0);
        tick();
        expect_out("s4_e4", 32'h00, 1'b0, 2'b11, 1'b0);
        check("s4_ready_underrun", 32'(pkt_ready), 32'd1);
        pkt_valid = 1'b1; pkt_data = 8'h32; pkt_last = 1'b1;
        tick();
        expect_out("s4_e5", 32'h32, 1'b1, 2'b00, 1'b0);
        pkt_valid = 1'b0; pkt_last = 1'b0;
        tick();
        expect_out("s4_e6", 32'hFD, 1'b0, 2'b01, 1'b0);
        tick();
        expect_out("s4_e7", 32'h00, 1'b0, 2'b11, 1'b0);

        // Scenario 5a: back-to-back single-symbol packets.
        start_reset("s5a");
        pkt_valid = 1'b1;
        tick();
        expect_out("s5a_e1", 32'hFB, 1'b0, 2'b01, 1'b0);
        pkt_data = 8'h77; pkt_last = 1'b1;
        tick();
        expect_out("s5a_e2", 32'h77, 1'b1, 2'b00, 1'b0);
        pkt_data = 8'h88; pkt_last = 1'b0;
        tick();
        expect_out("s5a_e3", 32'hFD, 1'b0, 2'b01, 1'b0);
        tick();
        expect_out("s5a_e4", 32'hFB, 1'b0, 2'b01, 1'b0);
        pkt_data = 8'h99; pkt_last = 1'b1;
        tick();
        expect_out("s5a_e5", 32'h99, 1'b1, 2'b00, 1'b0);
        pkt_valid = 1'b0; pkt_last = 1'b0;
        tick();
        expect_out("s5a_e6", 32'hFD, 1'b0, 2'b01, 1'b0);

        // Scenario 5b: packet waiting when the ordered set falls due.
        start_reset("s5b");
        run_idle("s5b", 1, 15);
        pkt_valid = 1'b1; pkt_data = 8'h5A; pkt_last = 1'b1;
        tick();
        expect_out("s5b_e16", 32'hBC, 1'b0, 2'b11, 1'b1);
        check("s5b_ready_os", 32'(pkt_ready), 32'd0);
        for (int e = 17; e <= 19; e++) begin
            tick();
            expect_out($sformatf("s5b_e%0d", e), 32'h1C, 1'b0, 2'b10, 1'b1);
        end
        tick();
        expect_out("s5b_e20", 32'hFB, 1'b0, 2'b01, 1'b0);
        tick();
        expect_out("s5b_e21", 32'h5A, 1'b1, 2'b00, 1'b0);
        pkt_valid = 1'b0; pkt_last = 1'b0;
        tick();
        expect_out("s5b_e22", 32'hFD, 1'b0, 2'b01, 1'b0);

        // Scenario 6: asynchronous reset mid-packet, then mid-ordered-set.
        start_reset("s6");
        pkt_valid = 1'b1;
        tick();
        pkt_data = 8'h61;
        tick();
        expect_out("s6_e2", 32'h61, 1'b1, 2'b00, 1'b0);
        #2 reset = 1'b1;
        #1;
        expect_out("s6_async_pkt", 32'h00, 1'b0, 2'b11, 1'b0);
        check("s6_async_pkt.ready", 32'(pkt_ready), 32'd0);
        pkt_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_idle("s6a", 1, 17);
        #2 reset = 1'b1;
        #1;
        expect_out("s6_async_os", 32'h00, 1'b0, 2'b11, 1'b0);
        check("s6_async_os.ready", 32'(pkt_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_idle("s6b", 1, 16);

        // Scenario 6, narrow-interval instance.
        check("p2_rst.d_out", 32'(d_out2), 32'h000);
        check("p2_rst.sel", 32'(sel2), 32'd3);
        @(negedge clk);
        reset2 = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 8) begin
                check($sformatf("p2_e%0d.d_out", e), 32'(d_out2), 32'h0BC);
                check($sformatf("p2_e%0d.sel", e), 32'(sel2), 32'd3);
                check($sformatf("p2_e%0d.os", e), 32'(os_active2), 32'd1);
            end else if (e == 9 || e == 10) begin
                check($sformatf("p2_e%0d.d_out", e), 32'(d_out2), 32'h01C);
                check($sformatf("p2_e%0d.sel", e), 32'(sel2), 32'd2);
                check($sformatf("p2_e%0d.os", e), 32'(os_active2), 32'd1);
            end else begin
                check($sformatf("p2_e%0d.d_out", e), 32'(d_out2), 32'h000);
                check($sformatf("p2_e%0d.sel", e), 32'(sel2), 32'd3);
                check($sformatf("p2_e%0d.os", e), 32'(os_active2), 32'd0);
            end
            check($sformatf("p2_e%0d.valid", e), 32'(valid2), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
